// File: rtl/data_mem_lat.sv
// data_mem_lat: fixed-latency data memory with request/ready handshake and saturating access counters
module data_mem_lat #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   adr,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic [DATA_W-1:0]   out,
  output logic                ready,
  output logic                busy,
  output logic                misalign,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    wr_count
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LC_W  = $clog2(LATENCY + 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_adr, w_adr;
  logic [DATA_W-1:0] r_data, w_data, r_out;
  logic [NB-1:0]     r_be, w_be;
  logic              r_wr, w_wr, r_mis, w_req, w_acc, w_mis;
  logic [LC_W-1:0]   r_cnt;
  logic [CNT_W-1:0]  r_rd_cnt, r_wr_cnt;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  assign w_req = mem_read | mem_write;
  // With LATENCY=1 the access happens on the acceptance edge itself, so the live inputs are used there
  assign w_acc  = (r_state == IDLE && w_req && LATENCY == 1) || (r_state == BUSY && r_cnt == LC_W'(1));
  assign w_adr  = (r_state == IDLE) ? adr       : r_adr;
  assign w_data = (r_state == IDLE) ? data      : r_data;
  assign w_be   = (r_state == IDLE) ? byte_en   : r_be;
  assign w_wr   = (r_state == IDLE) ? mem_write : r_wr;
  assign w_idx  = IDX_W'(w_adr >> OFF_W);
  assign w_mis  = |(w_adr & OFF_MASK);
  // Next-state selection
  always_comb begin
    w_next = (r_state == IDLE) ? (w_req ? ((LATENCY == 1) ? DONE : BUSY) : IDLE) :
             (r_state == BUSY) ? ((r_cnt == LC_W'(1)) ? DONE : BUSY) : IDLE;
  end
  // State register
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  // Request capture, latency countdown, read data and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= '0;
      r_mis    <= 1'b0;
      r_cnt    <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_adr  <= adr;
        r_data <= data;
        r_be   <= byte_en;
        r_wr   <= mem_write;
        r_cnt  <= LC_W'(LATENCY - 1);
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_acc) begin
        r_out <= r_mem[w_idx];
        r_mis <= w_mis;
        if (w_wr) r_wr_cnt <= (&r_wr_cnt) ? r_wr_cnt : r_wr_cnt + 1'b1;
        else      r_rd_cnt <= (&r_rd_cnt) ? r_rd_cnt : r_rd_cnt + 1'b1;
      end
    end
  end
  // Byte-masked write; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && w_acc && w_wr)
      for (int i = 0; i < NB; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
  end
  assign out      = r_out;
  assign ready    = (r_state == DONE);
  assign busy     = (r_state != IDLE);
  assign misalign = r_mis;
  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;
endmodule

// File: doc/data_mem_lat.md
# data_mem_lat

Parametrised, multi-cycle data memory for the pipelined CPU. It replaces the single-cycle data memory with a fixed-latency request/ready handshake, so the pipeline can be stalled against realistic memory timing. It supports configurable data width, depth and latency, per-byte write enables, and saturating access counters that benches read for performance checks.

## Interface
Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- ADDR_W, 32, byte-address width.
- DEPTH, 1024, number of DATA_W-bit words; power of two.
- LATENCY, 2, cycles from acceptance to ready; integer ≥ 1.
- CNT_W, 16, width of the access counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- adr  in  ADDR_W  byte address; word index = adr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)].
- data  in  DATA_W  write data.
- byte_en  in  DATA_W/8  per-byte write enable; ignored on reads.
- mem_read  in  1  read request.
- mem_write  in  1  write request.
- out  out  DATA_W  read data; valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while a request is in flight: BUSY state, or DONE state.
- misalign  out  1  the completed request had nonzero low address bits; valid with ready.
- rd_count  out  CNT_W  completed reads; saturating.
- wr_count  out  CNT_W  completed writes; saturating.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If mem_read or mem_write is high at an edge, the block captures adr, data, byte_en and op into internal registers. This is acceptance.
  - It then goes to BUSY with the counter loaded to LATENCY-1, or directly to DONE when LATENCY=1.
- BUSY:
  - The counter decrements each cycle.
  - At the edge where the counter equals 1, the block performs the access and enters DONE.
- DONE:
  - ready=1 for exactly one cycle, then the block returns to IDLE.
  - Request inputs are ignored in BUSY and DONE.
- Access is performed on the captured values:
  - out receives the addressed word.
  - For a write, each byte i with byte_en[i]=1 is replaced by the corresponding byte of the captured data.
- mem_read and mem_write both high at acceptance:
  - The request is treated as a write.
  - out returns the word as it was before the write (read-before-write).
  - Only wr_count increments.
- Address handling:
  - Low byte-offset bits are ignored for indexing; misalign reports them.
  - Upper bits above the index are ignored, so addresses wrap modulo DEPTH words.
- Counters increment at the access edge. At all-ones they hold (saturate).
- Requester protocol: hold the request until ready. The block does not require this, because the inputs are captured at acceptance.

## Timing
- Request accepted at the end of cycle 0.
- BUSY occupies cycles 1..LATENCY-1.
- ready, out and misalign are valid in cycle LATENCY.
- Earliest next acceptance: end of cycle LATENCY+1. Throughput is one access per LATENCY+1 cycles.
- A write is visible to any request accepted after its ready cycle.
- Reset values: state IDLE; out=0, ready=0, busy=0, misalign=0, rd_count=0, wr_count=0.
- Memory contents are not cleared by rst.
- rst wins over every other event in the same cycle.
- Reset mid-operation (BUSY): the request is abandoned with no memory update and no ready pulse.
- Reset during DONE: the write has already committed; ready drops the next cycle.
- A request presented in the same cycle as rst=1 is not accepted.

## Test plan
- LATENCY=2: write 0xDEADBEEF to adr 0x10 with byte_en=4'hF, then read 0x10 → ready high exactly 2 cycles after each acceptance; out=0xDEADBEEF; wr_count=1, rd_count=1.
- Byte enables: with word 0x11223344 at adr 0x20, write 0xAABBCCDD with byte_en=4'b0101, then read → out=0x11BB33DD.
- Simultaneous read and write: word 0x0 at adr 0x8, request 0x55 with both mem_read and mem_write high → out=0x0 in the ready cycle; a subsequent read returns 0x55; wr_count+1, rd_count unchanged.
- Wrap and misalign (DEPTH=1024): write 0x1234 to adr 0x1004, then read adr 0x0006 → out=0x1234 and misalign=1 on the read's ready.
- Reset mid-operation (LATENCY=4): write 0xFF to adr 0x0 holding 0x77, assert rst in cycle 2 → no ready pulse; counters=0; a later read returns 0x77.
- Saturation (CNT_W=4): 20 reads → rd_count holds at 15; LATENCY=1 back-to-back reads show ready every 2nd cycle.
